// File: rtl/id_ex_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg_if
// Bundle of every signal exchanged between the decode stage and the
// decode-to-execute pipeline register, excluding clk and reset.
//
//   stall, flush          : pipeline control from the hazard logic
//   id_*                  : decode-stage instruction fields and operands
//   wb_*                  : write-back port, same edge as the regfile write
//   ex_*                  : registered execute-stage fields
//   load_use_hazard       : combinational stall request back upstream
//
// Modports:
//   master : the surrounding pipeline (drives id/wb/control, reads ex)
//   slave  : the pipeline register itself
// ---------------------------------------------------------------------------
interface id_ex_pipe_reg_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [DATA_W-1:0] id_op1;
  logic [DATA_W-1:0] id_op2;
  logic [DATA_W-1:0] id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_reg_write;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              ex_valid;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [DATA_W-1:0] ex_op1;
  logic [DATA_W-1:0] ex_op2;
  logic [DATA_W-1:0] ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              load_use_hazard;

  modport master (
    output stall, flush, id_valid, id_rs1, id_rs2, id_rd,
    output id_op1, id_op2, id_imm, id_ctrl,
    output wb_reg_write, wb_rd, wb_data,
    input  ex_valid, ex_rs1, ex_rs2, ex_rd, ex_op1, ex_op2, ex_imm, ex_ctrl,
    input  load_use_hazard
  );

  modport slave (
    input  stall, flush, id_valid, id_rs1, id_rs2, id_rd,
    input  id_op1, id_op2, id_imm, id_ctrl,
    input  wb_reg_write, wb_rd, wb_data,
    output ex_valid, ex_rs1, ex_rs2, ex_rd, ex_op1, ex_op2, ex_imm, ex_ctrl,
    output load_use_hazard
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
// Decode-to-execute pipeline register for the 64-bit ARM core. Captures the
// regfile read operands, immediate, register specifiers and control word,
// with flush (bubble), stall (hold), write-back bypass for the regfile write
// happening at the same edge, and combinational load-use hazard detection.
//
// Ports:
//   clk   : system clock, all state updates on posedge
//   reset : synchronous active-high, clears every register
//   bus   : id_ex_pipe_reg_if.slave (stall/flush, id_*, wb_*, ex_*,
//           load_use_hazard)
//
// ex_ctrl layout: [2:0] alu_op, [3] alu_src, [4] mem_read, [5] mem_write,
//                 [6] reg_write, [7] branch
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  id_ex_pipe_reg_if.slave     bus
);

  localparam logic [4:0] XZR = 5'd31;

  // A write-back forwards into an operand only for a real register write that
  // targets the same (non-XZR) register being read this cycle.
  function automatic logic bypass_hit(input logic       wb_we,
                                      input logic [4:0] wb_rd,
                                      input logic [4:0] rs);
    return wb_we && (wb_rd != XZR) && (wb_rd == rs);
  endfunction

  logic              ex_valid_r;
  logic [4:0]        ex_rs1_r;
  logic [4:0]        ex_rs2_r;
  logic [4:0]        ex_rd_r;
  logic [DATA_W-1:0] ex_op1_r;
  logic [DATA_W-1:0] ex_op2_r;
  logic [DATA_W-1:0] ex_imm_r;
  logic [CTRL_W-1:0] ex_ctrl_r;

  logic [DATA_W-1:0] op1_next_s;
  logic [DATA_W-1:0] op2_next_s;
  logic [CTRL_W-1:0] ctrl_next_s;

  // Capture values: bypassed operands and a control word whose side-effect
  // bits are suppressed for non-instructions.
  always_comb begin
    op1_next_s  = bus.id_op1;
    op2_next_s  = bus.id_op2;
    ctrl_next_s = bus.id_ctrl;

    if (bypass_hit(bus.wb_reg_write, bus.wb_rd, bus.id_rs1)) begin
      op1_next_s = bus.wb_data;
    end else begin
      op1_next_s = bus.id_op1;
    end

    if (bypass_hit(bus.wb_reg_write, bus.wb_rd, bus.id_rs2)) begin
      op2_next_s = bus.wb_data;
    end else begin
      op2_next_s = bus.id_op2;
    end

    // mem_read/mem_write/reg_write/branch must never fire for an empty slot;
    // alu_op and alu_src are harmless and pass through unchanged.
    if (!bus.id_valid) begin
      ctrl_next_s[CTRL_W-1:4] = {(CTRL_W-4){1'b0}};
    end else begin
      ctrl_next_s = bus.id_ctrl;
    end
  end

  // Pipeline register: reset and flush both clear to a bubble, stall holds.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      ex_valid_r <= 1'b0;
      ex_rs1_r   <= 5'd0;
      ex_rs2_r   <= 5'd0;
      ex_rd_r    <= 5'd0;
      ex_op1_r   <= {DATA_W{1'b0}};
      ex_op2_r   <= {DATA_W{1'b0}};
      ex_imm_r   <= {DATA_W{1'b0}};
      ex_ctrl_r  <= {CTRL_W{1'b0}};
    end else if (!bus.stall) begin
      ex_valid_r <= bus.id_valid;
      ex_rs1_r   <= bus.id_rs1;
      ex_rs2_r   <= bus.id_rs2;
      ex_rd_r    <= bus.id_rd;
      ex_op1_r   <= op1_next_s;
      ex_op2_r   <= op2_next_s;
      ex_imm_r   <= bus.id_imm;
      ex_ctrl_r  <= ctrl_next_s;
    end
  end

  assign bus.ex_valid = ex_valid_r;
  assign bus.ex_rs1   = ex_rs1_r;
  assign bus.ex_rs2   = ex_rs2_r;
  assign bus.ex_rd    = ex_rd_r;
  assign bus.ex_op1   = ex_op1_r;
  assign bus.ex_op2   = ex_op2_r;
  assign bus.ex_imm   = ex_imm_r;
  assign bus.ex_ctrl  = ex_ctrl_r;

  // A load in EX whose destination is read by the instruction in ID cannot be
  // forwarded in time; raise the request in the same cycle.
  assign bus.load_use_hazard = bus.id_valid & ex_valid_r & ex_ctrl_r[4] &
                               (ex_rd_r != XZR) &
                               ((bus.id_rs1 == ex_rd_r) | (bus.id_rs2 == ex_rd_r));

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe_reg
// Directed, table-driven bench for id_ex_pipe_reg plus hand-written
// sequences for reset, stall/flush, load-use and reset-during-stall.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

  logic clk;
  logic reset;

  id_ex_pipe_reg_if #(.DATA_W(64), .CTRL_W(8)) bus ();

  id_ex_pipe_reg #(.DATA_W(64), .CTRL_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] imm;
    logic [7:0]  ctrl;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        e_valid;
    logic [63:0] e_op1;
    logic [63:0] e_op2;
    logic [7:0]  e_ctrl;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];
  vec_t va;
  vec_t vb;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid     = v.valid;
    bus.id_rs1       = v.rs1;
    bus.id_rs2       = v.rs2;
    bus.id_rd        = v.rd;
    bus.id_op1       = v.op1;
    bus.id_op2       = v.op2;
    bus.id_imm       = v.imm;
    bus.id_ctrl      = v.ctrl;
    bus.wb_reg_write = v.wb_we;
    bus.wb_rd        = v.wb_rd;
    bus.wb_data      = v.wb_data;
  endtask

  task automatic drive_random();
    bus.id_valid     = 1'($urandom);
    bus.id_rs1       = 5'($urandom);
    bus.id_rs2       = 5'($urandom);
    bus.id_rd        = 5'($urandom);
    bus.id_op1       = {$urandom, $urandom};
    bus.id_op2       = {$urandom, $urandom};
    bus.id_imm       = {$urandom, $urandom};
    bus.id_ctrl      = 8'($urandom);
    bus.wb_reg_write = 1'($urandom);
    bus.wb_rd        = 5'($urandom);
    bus.wb_data      = {$urandom, $urandom};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the EX side against a vector's expected outputs.
  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, ".valid"}, {63'd0, bus.ex_valid}, {63'd0, v.e_valid});
    chk({tag, ".rs1"},   {59'd0, bus.ex_rs1},   {59'd0, v.rs1});
    chk({tag, ".rs2"},   {59'd0, bus.ex_rs2},   {59'd0, v.rs2});
    chk({tag, ".rd"},    {59'd0, bus.ex_rd},    {59'd0, v.rd});
    chk({tag, ".op1"},   bus.ex_op1,            v.e_op1);
    chk({tag, ".op2"},   bus.ex_op2,            v.e_op2);
    chk({tag, ".imm"},   bus.ex_imm,            v.imm);
    chk({tag, ".ctrl"},  {56'd0, bus.ex_ctrl},  {56'd0, v.e_ctrl});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, {63'd0, bus.ex_valid}, 64'd0);
    chk({tag, ".rs1"},   {59'd0, bus.ex_rs1},   64'd0);
    chk({tag, ".rs2"},   {59'd0, bus.ex_rs2},   64'd0);
    chk({tag, ".rd"},    {59'd0, bus.ex_rd},    64'd0);
    chk({tag, ".op1"},   bus.ex_op1,            64'd0);
    chk({tag, ".op2"},   bus.ex_op2,            64'd0);
    chk({tag, ".imm"},   bus.ex_imm,            64'd0);
    chk({tag, ".ctrl"},  {56'd0, bus.ex_ctrl},  64'd0);
  endtask

  task automatic check_hz(input string tag, input logic exp);
    chk(tag, {63'd0, bus.load_use_hazard}, {63'd0, exp});
  endtask

  initial begin
    // valid rs1 rs2 rd op1 op2 imm ctrl wb_we wb_rd wb_data | e_valid e_op1 e_op2 e_ctrl
    vecs[0] = '{1'b1, 5'd1,  5'd2,  5'd3,  64'h1234, 64'h55,   64'h10,  8'h43, 1'b0, 5'd0,  64'h0,
                1'b1, 64'h1234, 64'h55, 8'h43};
    vecs[1] = '{1'b1, 5'd5,  5'd5,  5'd6,  64'h1,    64'h1,    64'h20,  8'h12, 1'b1, 5'd5,  64'hDEAD_BEEF,
                1'b1, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 8'h12};
    vecs[2] = '{1'b1, 5'd31, 5'd4,  5'd7,  64'h0,    64'h77,   64'h30,  8'h44, 1'b1, 5'd31, 64'hCAFE,
                1'b1, 64'h0, 64'h77, 8'h44};
    vecs[3] = '{1'b0, 5'd8,  5'd9,  5'd10, 64'h99,   64'h88,   64'h40,  8'hFF, 1'b0, 5'd0,  64'h0,
                1'b0, 64'h99, 64'h88, 8'h0F};
    vecs[4] = '{1'b1, 5'd7,  5'd8,  5'd2,  64'h111,  64'h222,  64'h50,  8'h61, 1'b1, 5'd7,  64'hABC,
                1'b1, 64'hABC, 64'h222, 8'h61};
    vecs[5] = '{1'b1, 5'd9,  5'd12, 5'd13, 64'h333,  64'h444,  64'h60,  8'h80, 1'b0, 5'd9,  64'h5555,
                1'b1, 64'h333, 64'h444, 8'h80};
    vecs[6] = '{1'b1, 5'd11, 5'd10, 5'd14, 64'h666,  64'h777,  64'h70,  8'h2B, 1'b1, 5'd10, 64'hF00D,
                1'b1, 64'h666, 64'hF00D, 8'h2B};
    vecs[7] = '{1'b0, 5'd3,  5'd3,  5'd3,  64'hAAAA, 64'hBBBB, 64'h80,  8'hA5, 1'b1, 5'd3,  64'h7777,
                1'b0, 64'h7777, 64'h7777, 8'h05};

    va = '{1'b1, 5'd20, 5'd21, 5'd22, 64'hA1A1, 64'hA2A2, 64'hA3A3, 8'h4A, 1'b0, 5'd0, 64'h0,
           1'b1, 64'hA1A1, 64'hA2A2, 8'h4A};

    bus.stall = 1'b0;
    bus.flush = 1'b0;
    reset     = 1'b1;
    drive_random();

    // Reset held for two edges with random inputs.
    for (int i = 0; i < 2; i++) begin
      tick();
      check_zero($sformatf("reset%0d", i));
      drive_random();
    end
    reset = 1'b0;

    // Table-driven captures, one edge each.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      tick();
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Stall holds A for three edges while inputs change.
    drive(va);
    tick();
    check_vec("loadA", va);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      tick();
      check_vec($sformatf("stall%0d", i), va);
    end

    // Flush wins over stall.
    bus.flush = 1'b1;
    tick();
    check_zero("flush_over_stall");
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // Load-use: EX holds a load to x3.
    vb = '{1'b1, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 64'h3, 8'h50, 1'b0, 5'd0, 64'h0,
           1'b1, 64'h1, 64'h2, 8'h50};
    drive(vb);
    tick();
    check_vec("load_in_ex", vb);
    bus.id_valid = 1'b1;
    bus.id_rs1   = 5'd0;
    bus.id_rs2   = 5'd3;
    #1;
    check_hz("hz_rs2", 1'b1);
    bus.id_rs1 = 5'd3;
    bus.id_rs2 = 5'd0;
    #1;
    check_hz("hz_rs1", 1'b1);
    bus.id_valid = 1'b0;
    #1;
    check_hz("hz_id_invalid", 1'b0);
    bus.id_valid = 1'b1;
    bus.id_rs1   = 5'd4;
    bus.id_rs2   = 5'd5;
    #1;
    check_hz("hz_no_match", 1'b0);

    // Load to XZR never creates a hazard.
    vb.rd = 5'd31;
    drive(vb);
    tick();
    bus.id_valid = 1'b1;
    bus.id_rs1   = 5'd31;
    bus.id_rs2   = 5'd31;
    #1;
    check_hz("hz_xzr", 1'b0);

    // Non-load in EX never creates a hazard.
    vb.rd   = 5'd3;
    vb.ctrl = 8'h40;
    drive(vb);
    tick();
    bus.id_valid = 1'b1;
    bus.id_rs1   = 5'd0;
    bus.id_rs2   = 5'd3;
    #1;
    check_hz("hz_not_load", 1'b0);

    // Reset during a stall clears everything at that edge.
    drive(va);
    tick();
    check_vec("loadA2", va);
    bus.stall = 1'b1;
    drive_random();
    tick();
    check_vec("stall_before_reset", va);
    reset = 1'b1;
    tick();
    check_zero("reset_mid_stall");
    reset     = 1'b0;
    bus.stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg
Overview: Decode-to-execute pipeline register for the 64-bit ARM core. It sits directly downstream of the 32x64 register file and captures the two read operands, immediate, register specifiers and control word each cycle. It also provides stall/flush, write-back bypass for same-cycle regfile writes, and load-use hazard detection.
Parameters:
DATA_W, 64, operand/immediate width
CTRL_W, 8, control word width
Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high; clears all state
stall  in  1  hold current EX contents
flush  in  1  insert bubble into EX (priority over stall)
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  5  source register 1 index (31 = XZR)
id_rs2  in  5  source register 2 index
id_rd  in  5  destination register index
id_op1  in  DATA_W  regfile read data port 1
id_op2  in  DATA_W  regfile read data port 2
id_imm  in  DATA_W  sign-extended immediate
id_ctrl  in  CTRL_W  [2:0] alu_op, [3] alu_src, [4] mem_read, [5] mem_write, [6] reg_write, [7] branch
wb_reg_write  in  1  write-back stage writing regfile this cycle
wb_rd  in  5  write-back destination index
wb_data  in  DATA_W  write-back data
ex_valid  out  1  EX holds a real instruction
ex_rs1, ex_rs2, ex_rd  out  5 each  registered specifiers, for the downstream forwarding unit
ex_op1, ex_op2, ex_imm  out  DATA_W each  registered operands/immediate
ex_ctrl  out  CTRL_W  registered control word
load_use_hazard  out  1  combinational; request to the upstream stall logic
Behaviour:
- Priority at each posedge: reset > flush > stall > capture.
- Reset: every registered output is 0, including ex_valid and ex_ctrl.
- Flush: ex_valid, ex_ctrl, ex_op1/op2/imm and ex_rs1/rs2/rd all load 0. A bubble therefore never writes the regfile or touches memory.
- Stall (flush=0): all registers hold their value. This covers stall held for many cycles.
- Capture (no stall or flush): ex_* load id_*, and ex_valid loads id_valid.
  - If id_valid=0, ex_ctrl[7:4] load 0. ex_ctrl[3:0] and the data fields are captured as-is.
- Write-back bypass during capture: the regfile writes at the same edge, so its read data is stale.
  - If wb_reg_write=1, wb_rd!=31 and wb_rd==id_rs1, ex_op1 loads wb_data instead of id_op1. Same rule for op2 with id_rs2.
  - Both operands may bypass in the same cycle.
  - wb_rd==31 never bypasses, so XZR reads stay 0.
- id_rs==31 always passes id_op through. The regfile supplies 0 for XZR.
- load_use_hazard = id_valid & ex_valid & ex_ctrl[4] & (ex_rd!=31) & ((id_rs1==ex_rd) | (id_rs2==ex_rd)).
  - It is purely combinational with no registered delay.
  - The upstream logic drives stall=0 and flush=1 into this block on the following edge.
  - The block does not self-stall.
- Latency: exactly 1 cycle from ID inputs to EX outputs when not stalled.
- No X propagation: outputs are defined from the first edge with reset=1.
Test Plan:
- Reset: reset=1 for 2 edges with random inputs -> all ex_* = 0, ex_valid=0, ex_ctrl=8'h00. Then reset=0 and id_valid=1, id_op1=64'h1234, id_ctrl=8'h43 -> next edge ex_op1=64'h1234, ex_ctrl=8'h43, ex_valid=1.
- Stall/flush: load value A, then stall=1 for 3 edges with changing inputs -> ex_* stay A. Assert stall=1 and flush=1 together -> ex_valid=0, ex_ctrl=0, ex_op1=0.
- Bypass: id_rs1=5, id_rs2=5, id_op1=id_op2=64'h1; wb_reg_write=1, wb_rd=5, wb_data=64'hDEAD_BEEF -> ex_op1=ex_op2=64'hDEAD_BEEF. Repeat with wb_rd=31, id_rs1=31, id_op1=0 -> ex_op1=0.
- Invalid capture: id_valid=0, id_ctrl=8'hFF -> ex_valid=0, ex_ctrl=8'h0F.
- Load-use: EX holds ex_ctrl[4]=1, ex_rd=3, ex_valid=1; ID has id_valid=1, id_rs2=3 -> load_use_hazard=1 in the same cycle.
  - Same case with ex_rd=31 -> load_use_hazard=0.
  - Same case with ex_ctrl[4]=0 -> load_use_hazard=0.
- Reset mid-stall: stall=1 holding non-zero data, then reset=1 for 1 edge -> all outputs 0 at that edge.
